// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: the FSM state encoding,
// default sizes, and the core-index width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    RESPOND = 2'b10,
    RELEASE = 2'b11
  } arb_state_e;

  localparam int MA_NUM_CORES = 4;
  localparam int MA_ADDR_BITS = 8;
  localparam int MA_DATA_BITS = 8;

  // Bits needed to name one of n cores.
  // The floor of 1 keeps the index a legal vector for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MA_IDX_W = idx_width(MA_NUM_CORES);

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the per-core request/response lines and the memory-side port.
// The slave modport is the arbiter; the master modport is the core/memory side.
interface mem_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [NUM_CORES-1:0]           req_valid;
  logic [NUM_CORES-1:0]           req_we;
  logic [NUM_CORES*ADDR_BITS-1:0] req_addr;
  logic [NUM_CORES*DATA_BITS-1:0] req_wdata;
  logic [NUM_CORES-1:0]           rsp_valid;
  logic [DATA_BITS-1:0]           rsp_rdata;
  logic                           mem_valid;
  logic                           mem_we;
  logic [ADDR_BITS-1:0]           mem_addr;
  logic [DATA_BITS-1:0]           mem_wdata;
  logic                           mem_ready;
  logic [DATA_BITS-1:0]           mem_rdata;
  logic                           busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
    output rsp_valid, rsp_rdata, mem_valid, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
    input  rsp_valid, rsp_rdata, mem_valid, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter_rr_priority_picker.sv
// Round-robin priority picker: returns the first set request bit found when
// scanning ptr, ptr+1, ... modulo N. Purely combinational.
module rr_priority_picker
  import mem_arbiter_pkg::*;
#(
  parameter int N     = MA_NUM_CORES,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] grant_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    found_o  = 1'b0;
    grant_o  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand     = (int'(ptr_i) + k) % N;
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) begin
        found_o = 1'b1;
        grant_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_CORES compute
// units. One transaction at a time: grant, issue to memory, pulse the
// response to the granted core, then wait for that core to drop its request.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = MA_NUM_CORES,
  parameter int ADDR_BITS = MA_ADDR_BITS,
  parameter int DATA_BITS = MA_DATA_BITS
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_width(NUM_CORES);

  arb_state_e           state_q,     state_d;
  logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]     grant_q,     grant_d;
  logic [NUM_CORES-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_we_q,    mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic                 busy_q,      busy_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;

  rr_priority_picker #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .grant_o (pick_idx)
  );

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          mem_we_d    = bus.req_we[pick_idx];
          mem_addr_d  = bus.req_addr[pick_idx*ADDR_BITS +: ADDR_BITS];
          mem_wdata_d = bus.req_wdata[pick_idx*DATA_BITS +: DATA_BITS];
          mem_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          mem_valid_d          = 1'b0;
          rsp_valid_d          = '0;
          rsp_valid_d[grant_q] = 1'b1;
          if (!mem_we_q) rsp_rdata_d = bus.mem_rdata;
          state_d              = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid_d = '0;
        rr_ptr_d    = (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + IDX_W'(1);
        state_d     = RELEASE;
      end
      RELEASE: begin
        // Hold here until the serviced core lets go, so its stale request
        // cannot win a second grant.
        if (!bus.req_valid[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule
